functional_unit_cluster: RTL and testbench
==========================================

Name: functional_unit_cluster

Overview:
- Parametrised successor to the single-ALU/single-branch functional unit.
- Contains NUM_ALU ALU channels and one branch channel. Each channel has its own result buffer.
- A registered common-data-bus (CDB) arbiter broadcasts one result per cycle.
- Sits between the reservation stations (issue side) and the ROB/reservation-station CDB snoop (writeback side); per-channel buffer back-pressure replaces the old single-entry available flags.

Parameters:
- WIDTH, 32, datapath width.
- ROB, 3, ROB tag width.
- NUM_ALU, 2, number of ALU channels (1..4).
- BUF_DEPTH, 2, result FIFO entries per ALU channel (power of 2, ≥1).
- CONTROL, 7, CDB control-field width.

Ports:
- clk  in  1  clock.
- globalReset  in  1  synchronous active-high reset.
- aluValid  in  NUM_ALU  issue strobe per ALU channel.
- aluSrc1, aluSrc2  in  NUM_ALU*WIDTH  operands, channel i at bits [i*WIDTH +: WIDTH].
- aluControl  in  NUM_ALU*4  opcode per channel.
- aluRob  in  NUM_ALU*ROB  destination tag per channel.
- aluAvailable  out  NUM_ALU  channel FIFO not full.
- brValid  in  1  branch issue strobe.
- bSrc1, bSrc2  in  WIDTH  compare operands.
- targetAddress, predictedPC, pcPlus4, linkValue  in  WIDTH  branch addresses.
- branchControl  in  3  BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR (0..7).
- predictedTaken  in  1.
- counterState  in  2  BTB 2-bit counter.
- branchRob  in  ROB.
- branchAvailable  out  1.
- cdbValid  out  1.
- cdbRob  out  ROB.
- cdbResult  out  WIDTH.
- cdbAddress  out  WIDTH  correct fetch address.
- cdbControl  out  CONTROL  {mispredict, misdirect, nextState[1:0], writeBTB, taken, isBranch}.

Behaviour:
- Reset, synchronous on globalReset:
  - All FIFOs empty; round-robin pointer = 0.
  - cdbValid = 0; cdbRob, cdbResult, cdbAddress, cdbControl = 0.
  - aluAvailable = all 1; branchAvailable = 1.
  - An in-flight result or issue in the same cycle is discarded.
- ALU opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU; others produce 0.
  - Shift amount = src2[4:0].
  - Results wrap modulo 2^WIDTH.
- ALU issue: aluValid[i] & aluAvailable[i] pushes {rob, result} at the clock edge.
  - aluValid while not available is ignored; the issuer must hold it.
- Branch resolution, combinational at issue, stored in a 1-entry buffer:
  - taken = condition result; JAL and JALR always taken.
  - mispredict = taken ≠ predictedTaken.
  - misdirect = taken & (targetAddress ≠ predictedPC).
  - correct address = taken ? targetAddress : pcPlus4.
  - writeBTB = taken.
  - nextState = saturating counterState ±1 (taken increments, saturates at 3; not-taken decrements, saturates at 0).
  - result field = linkValue.
- Arbitration, each cycle:
  - Branch buffer non-empty → branch wins.
  - Otherwise round-robin over non-empty ALU FIFOs, starting at the pointer. The pointer advances to winner+1 mod NUM_ALU.
  - Winner pops; CDB registers load at the edge.
  - cdbValid in the cycle after selection; cdbValid = 0 when nothing is pending.
- Latency: issue at cycle t → earliest cdbValid at cycle t+2.
- Availability:
  - aluAvailable[i] = count < BUF_DEPTH, registered view.
  - Push and pop in the same cycle on a full FIFO is not allowed; available stays 0 until a pop.
  - Push and pop on a non-full FIFO leaves the count unchanged.
- Starvation bound: every non-empty ALU FIFO is granted within NUM_ALU non-branch cycles.
- cdbControl for ALU results = 0.

Optional Feature:
- Macro FU_PERF_CNT_EN.
- Defined: adds output stallCycles (32 bits) and input perfClear.
  - stallCycles increments each cycle any channel is unavailable, saturating at all-ones.
  - Cleared by globalReset or perfClear; clear wins over increment.
- Undefined: neither port exists and there is no counter logic.

Decomposition:
- Package fu_pkg:
  - ALU opcode enum.
  - Branch opcode enum.
  - cdb_ctrl_t packed struct matching cdbControl.
  - Localparams for counter saturation limits.
- Sub-module result_fifo (parameters WIDTH+ROB payload, BUF_DEPTH).
  - Ports: push, pop, data, full, empty.
  - Instantiated NUM_ALU times; the branch buffer uses depth 1.

Test Plan:
- ALU0 ADD 5+7, rob 3, issued at t → cdbValid at t+2: rob 3, result 12, control 0.
- Simultaneous ALU0, ALU1 and branch issue:
  - Branch broadcast first.
  - Then ALU0, then ALU1.
  - The next contention starts at ALU0 again, since the pointer has wrapped to 0.
- BEQ 4==4, predictedTaken 0, target 0x100, counterState 1 → mispredict 1, taken 1, address 0x100, nextState 2.
  - BNE 4==4, predictedTaken 0, counterState 0 → no mispredict, address = pcPlus4, nextState 0.
- Hold ALU0 issue with branch issue every cycle, BUF_DEPTH = 2 → aluAvailable[0] drops after 2 pushes and rises after the first ALU0 grant.
- globalReset asserted with a full FIFO → next cycle all available, cdbValid = 0, no stale broadcast.
- With FU_PERF_CNT_EN, stall for 5 cycles → stallCycles = 5; perfClear → 0.

Source files
------------

// File: rtl/fu_pkg.sv
// Shared types for the functional unit cluster: opcodes, CDB control layout and
// branch-predictor counter limits.
package fu_pkg;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluSll  = 4'd5,
    AluSrl  = 4'd6,
    AluSra  = 4'd7,
    AluSlt  = 4'd8,
    AluSltu = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    BrBeq  = 3'd0,
    BrBne  = 3'd1,
    BrBlt  = 3'd2,
    BrBge  = 3'd3,
    BrBltu = 3'd4,
    BrBgeu = 3'd5,
    BrJal  = 3'd6,
    BrJalr = 3'd7
  } br_op_e;

  typedef struct packed {
    logic       mispredict;
    logic       misdirect;
    logic [1:0] next_state;
    logic       write_btb;
    logic       taken;
    logic       is_branch;
  } cdb_ctrl_t;

  localparam int unsigned CdbCtrlW = $bits(cdb_ctrl_t);
  localparam logic [1:0]  CntMax   = 2'd3;
  localparam logic [1:0]  CntMin   = 2'd0;

  // Saturating 2-bit predictor update.
  function automatic logic [1:0] next_counter(input logic [1:0] cur, input logic taken);
    if (taken) begin
      next_counter = (cur == CntMax) ? CntMax : cur + 2'd1;
    end else begin
      next_counter = (cur == CntMin) ? CntMin : cur - 2'd1;
    end
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO holding results until the CDB arbiter grants them.
// Pushes while full and pops while empty are ignored.
module result_fifo #(
  parameter int unsigned WIDTH = 35,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned    PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned    CntW    = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/functional_unit_cluster.sv
// NUM_ALU ALU channels plus one branch channel feeding a registered CDB arbiter.
// Optional stall counter enabled by defining FU_PERF_CNT_EN.
module functional_unit_cluster
  import fu_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ROB       = 3,
  parameter int unsigned NUM_ALU   = 2,
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned CONTROL   = 7
) (
  input  logic                   clk,
  input  logic                   globalReset,
`ifdef FU_PERF_CNT_EN
  input  logic                   perfClear,
  output logic [31:0]            stallCycles,
`endif
  input  logic [NUM_ALU-1:0]     aluValid,
  input  logic [NUM_ALU*WIDTH-1:0] aluSrc1,
  input  logic [NUM_ALU*WIDTH-1:0] aluSrc2,
  input  logic [NUM_ALU*4-1:0]   aluControl,
  input  logic [NUM_ALU*ROB-1:0] aluRob,
  output logic [NUM_ALU-1:0]     aluAvailable,
  input  logic                   brValid,
  input  logic [WIDTH-1:0]       bSrc1,
  input  logic [WIDTH-1:0]       bSrc2,
  input  logic [WIDTH-1:0]       targetAddress,
  input  logic [WIDTH-1:0]       predictedPC,
  input  logic [WIDTH-1:0]       pcPlus4,
  input  logic [WIDTH-1:0]       linkValue,
  input  logic [2:0]             branchControl,
  input  logic                   predictedTaken,
  input  logic [1:0]             counterState,
  input  logic [ROB-1:0]         branchRob,
  output logic                   branchAvailable,
  output logic                   cdbValid,
  output logic [ROB-1:0]         cdbRob,
  output logic [WIDTH-1:0]       cdbResult,
  output logic [WIDTH-1:0]       cdbAddress,
  output logic [CONTROL-1:0]     cdbControl
);

  localparam int unsigned    AluPayW = ROB + WIDTH;
  localparam int unsigned    BrPayW  = ROB + 2 * WIDTH + CdbCtrlW;
  localparam int unsigned    RrW     = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1;
  localparam logic [RrW-1:0] LastAlu = RrW'(NUM_ALU - 1);

  function automatic logic [WIDTH-1:0] alu_compute(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic [3:0] op);
    logic [4:0] sh;
    sh = b[4:0];
    case (alu_op_e'(op))
      AluAdd:  alu_compute = a + b;
      AluSub:  alu_compute = a - b;
      AluAnd:  alu_compute = a & b;
      AluOr:   alu_compute = a | b;
      AluXor:  alu_compute = a ^ b;
      AluSll:  alu_compute = a << sh;
      AluSrl:  alu_compute = a >> sh;
      AluSra:  alu_compute = $signed(a) >>> sh;
      AluSlt:  alu_compute = WIDTH'($signed(a) < $signed(b));
      AluSltu: alu_compute = WIDTH'(a < b);
      default: alu_compute = '0;
    endcase
  endfunction

  // ALU channels
  logic [WIDTH-1:0]   alu_res   [NUM_ALU];
  logic [AluPayW-1:0] alu_rdata [NUM_ALU];
  logic [NUM_ALU-1:0] alu_full, alu_empty, alu_pop;

  always_comb begin
    for (int i = 0; i < NUM_ALU; i++) begin
      alu_res[i] = alu_compute(aluSrc1[i*WIDTH +: WIDTH], aluSrc2[i*WIDTH +: WIDTH],
                               aluControl[i*4 +: 4]);
    end
  end

  for (genvar g = 0; g < NUM_ALU; g++) begin : g_alu
    result_fifo #(
      .WIDTH (AluPayW),
      .DEPTH (BUF_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (globalReset),
      .push  (aluValid[g]),
      .pop   (alu_pop[g]),
      .wdata ({aluRob[g*ROB +: ROB], alu_res[g]}),
      .rdata (alu_rdata[g]),
      .full  (alu_full[g]),
      .empty (alu_empty[g])
    );
  end

  assign aluAvailable = ~alu_full;

  // Branch channel: resolved at issue, buffered one deep
  logic             br_taken;
  cdb_ctrl_t        br_ctrl, br_ctrl_out;
  logic [WIDTH-1:0] br_addr, br_addr_out, br_link_out;
  logic [ROB-1:0]   br_rob_out;
  logic [BrPayW-1:0] br_rdata;
  logic             br_full, br_empty;

  always_comb begin
    case (br_op_e'(branchControl))
      BrBeq:  br_taken = (bSrc1 == bSrc2);
      BrBne:  br_taken = (bSrc1 != bSrc2);
      BrBlt:  br_taken = ($signed(bSrc1) < $signed(bSrc2));
      BrBge:  br_taken = ($signed(bSrc1) >= $signed(bSrc2));
      BrBltu: br_taken = (bSrc1 < bSrc2);
      BrBgeu: br_taken = (bSrc1 >= bSrc2);
      default: br_taken = 1'b1;
    endcase
    br_ctrl.mispredict = br_taken ^ predictedTaken;
    br_ctrl.misdirect  = br_taken & (targetAddress != predictedPC);
    br_ctrl.next_state = next_counter(counterState, br_taken);
    br_ctrl.write_btb  = br_taken;
    br_ctrl.taken      = br_taken;
    br_ctrl.is_branch  = 1'b1;
    br_addr            = br_taken ? targetAddress : pcPlus4;
  end

  result_fifo #(
    .WIDTH (BrPayW),
    .DEPTH (1)
  ) u_br_fifo (
    .clk   (clk),
    .reset (globalReset),
    .push  (brValid),
    .pop   (~br_empty),
    .wdata ({branchRob, linkValue, br_addr, br_ctrl}),
    .rdata (br_rdata),
    .full  (br_full),
    .empty (br_empty)
  );

  assign {br_rob_out, br_link_out, br_addr_out, br_ctrl_out} = br_rdata;
  assign branchAvailable = ~br_full;

  // Arbitration: branch first, then round-robin over ALU FIFOs from rr_q
  logic [RrW-1:0] rr_q, rr_d, alu_win, scan_idx;
  logic [RrW:0]   scan_sum;
  logic           alu_found;

  always_comb begin
    alu_found = 1'b0;
    alu_win   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_ALU; k++) begin
      scan_sum = {1'b0, rr_q} + (RrW + 1)'(k);
      if (scan_sum >= (RrW + 1)'(NUM_ALU)) begin
        scan_sum = scan_sum - (RrW + 1)'(NUM_ALU);
      end
      scan_idx = scan_sum[RrW-1:0];
      if (!alu_found && !alu_empty[scan_idx]) begin
        alu_found = 1'b1;
        alu_win   = scan_idx;
      end
    end
  end

  for (genvar g = 0; g < NUM_ALU; g++) begin : g_pop
    assign alu_pop[g] = br_empty & alu_found & (alu_win == RrW'(g));
  end

  logic               cdb_valid_d;
  logic [ROB-1:0]     cdb_rob_d;
  logic [WIDTH-1:0]   cdb_result_d, cdb_address_d;
  logic [CONTROL-1:0] cdb_control_d;

  always_comb begin
    cdb_valid_d   = 1'b0;
    cdb_rob_d     = '0;
    cdb_result_d  = '0;
    cdb_address_d = '0;
    cdb_control_d = '0;
    rr_d          = rr_q;
    if (!br_empty) begin
      cdb_valid_d   = 1'b1;
      cdb_rob_d     = br_rob_out;
      cdb_result_d  = br_link_out;
      cdb_address_d = br_addr_out;
      cdb_control_d = CONTROL'(br_ctrl_out);
    end else if (alu_found) begin
      cdb_valid_d                = 1'b1;
      {cdb_rob_d, cdb_result_d} = alu_rdata[alu_win];
      rr_d = (alu_win == LastAlu) ? '0 : alu_win + RrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (globalReset) begin
      rr_q       <= '0;
      cdbValid   <= 1'b0;
      cdbRob     <= '0;
      cdbResult  <= '0;
      cdbAddress <= '0;
      cdbControl <= '0;
    end else begin
      rr_q       <= rr_d;
      cdbValid   <= cdb_valid_d;
      cdbRob     <= cdb_rob_d;
      cdbResult  <= cdb_result_d;
      cdbAddress <= cdb_address_d;
      cdbControl <= cdb_control_d;
    end
  end

`ifdef FU_PERF_CNT_EN
  logic [31:0] stall_q;
  logic        any_unavail;

  assign any_unavail = ~(&aluAvailable) | ~branchAvailable;

  always_ff @(posedge clk) begin
    if (globalReset || perfClear) begin
      stall_q <= '0;
    end else if (any_unavail && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stallCycles = stall_q;
`endif

endmodule

// File: tb/tb_functional_unit_cluster.sv
// Self-checking bench: directed cases with literal expectations plus random traffic
// compared every cycle against a queue-based model of the cluster.
module tb_functional_unit_cluster;

  localparam int W = 32;
  localparam int R = 3;
  localparam int N = 2;
  localparam int D = 2;
  localparam int C = 7;

  logic           clk = 1'b0;
  logic           globalReset;
  logic [N-1:0]   aluValid;
  logic [N*W-1:0] aluSrc1, aluSrc2;
  logic [N*4-1:0] aluControl;
  logic [N*R-1:0] aluRob;
  logic [N-1:0]   aluAvailable;
  logic           brValid;
  logic [W-1:0]   bSrc1, bSrc2, targetAddress, predictedPC, pcPlus4, linkValue;
  logic [2:0]     branchControl;
  logic           predictedTaken;
  logic [1:0]     counterState;
  logic [R-1:0]   branchRob;
  logic           branchAvailable;
  logic           cdbValid;
  logic [R-1:0]   cdbRob;
  logic [W-1:0]   cdbResult, cdbAddress;
  logic [C-1:0]   cdbControl;
`ifdef FU_PERF_CNT_EN
  logic           perfClear;
  logic [31:0]    stallCycles;
`endif

  functional_unit_cluster #(
    .WIDTH(W), .ROB(R), .NUM_ALU(N), .BUF_DEPTH(D), .CONTROL(C)
  ) dut (
    .clk            (clk),
    .globalReset    (globalReset),
`ifdef FU_PERF_CNT_EN
    .perfClear      (perfClear),
    .stallCycles    (stallCycles),
`endif
    .aluValid       (aluValid),
    .aluSrc1        (aluSrc1),
    .aluSrc2        (aluSrc2),
    .aluControl     (aluControl),
    .aluRob         (aluRob),
    .aluAvailable   (aluAvailable),
    .brValid        (brValid),
    .bSrc1          (bSrc1),
    .bSrc2          (bSrc2),
    .targetAddress  (targetAddress),
    .predictedPC    (predictedPC),
    .pcPlus4        (pcPlus4),
    .linkValue      (linkValue),
    .branchControl  (branchControl),
    .predictedTaken (predictedTaken),
    .counterState   (counterState),
    .branchRob      (branchRob),
    .branchAvailable(branchAvailable),
    .cdbValid       (cdbValid),
    .cdbRob         (cdbRob),
    .cdbResult      (cdbResult),
    .cdbAddress     (cdbAddress),
    .cdbControl     (cdbControl)
  );

  initial forever #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [R-1:0] rob;
    logic [W-1:0] res;
    logic [W-1:0] addr;
    logic [C-1:0] ctrl;
    logic         is_br;
  } ent_t;

  ent_t        aq [N][D];
  int          acnt [N];
  ent_t        bq;
  int          bcnt;
  int          rr;
  ent_t        exp_e;
  bit          exp_v;
  bit          started = 1'b0;
  int unsigned stall_m;

  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input int op);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << sh;
      6: return a >> sh;
      7: return W'($signed(a) >>> sh);
      8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      9: return (a < b) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  function automatic ent_t ref_branch();
    ent_t e;
    bit   t;
    int   ns;
    case (int'(branchControl))
      0: t = (bSrc1 == bSrc2);
      1: t = (bSrc1 != bSrc2);
      2: t = ($signed(bSrc1) < $signed(bSrc2));
      3: t = ($signed(bSrc1) >= $signed(bSrc2));
      4: t = (bSrc1 < bSrc2);
      5: t = (bSrc1 >= bSrc2);
      default: t = 1'b1;
    endcase
    ns = int'(counterState) + (t ? 1 : -1);
    if (ns > 3) ns = 3;
    if (ns < 0) ns = 0;
    e.rob   = branchRob;
    e.res   = linkValue;
    e.addr  = t ? targetAddress : pcPlus4;
    e.ctrl  = {t != predictedTaken, t && (targetAddress != predictedPC), 2'(ns), t, t, 1'b1};
    e.is_br = 1'b1;
    return e;
  endfunction

  task automatic model_step();
    bit   av [N];
    bit   bav, won, stall;
    int   w;
    ent_t e;
    stall = 1'b0;
    for (int i = 0; i < N; i++) begin
      av[i] = acnt[i] < D;
      if (!av[i]) stall = 1'b1;
    end
    bav = (bcnt == 0);
    if (!bav) stall = 1'b1;
`ifdef FU_PERF_CNT_EN
    if (globalReset || perfClear) stall_m = 0;
    else if (stall && stall_m != 32'hFFFF_FFFF) stall_m++;
`endif
    if (globalReset) begin
      for (int i = 0; i < N; i++) acnt[i] = 0;
      bcnt    = 0;
      rr      = 0;
      exp_v   = 1'b0;
      exp_e   = '0;
      started = 1'b1;
      return;
    end
    won   = 1'b0;
    exp_e = '0;
    if (bcnt > 0) begin
      exp_e = bq;
      bcnt  = 0;
      won   = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        w = (rr + k) % N;
        if (!won && acnt[w] > 0) begin
          exp_e = aq[w][0];
          for (int j = 0; j < D - 1; j++) aq[w][j] = aq[w][j+1];
          acnt[w]--;
          rr  = (w + 1) % N;
          won = 1'b1;
        end
      end
    end
    exp_v = won;
    for (int i = 0; i < N; i++) begin
      if (aluValid[i] && av[i]) begin
        e       = '0;
        e.rob   = aluRob[i*R +: R];
        e.res   = ref_alu(aluSrc1[i*W +: W], aluSrc2[i*W +: W], int'(aluControl[i*4 +: 4]));
        aq[i][acnt[i]] = e;
        acnt[i]++;
      end
    end
    if (brValid && bav) begin
      bq   = ref_branch();
      bcnt = 1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (started) begin
      for (int i = 0; i < N; i++) chk("m_alu_avail", aluAvailable[i], acnt[i] < D);
      chk("m_br_avail", branchAvailable, bcnt == 0);
      chk("m_cdb_valid", cdbValid, exp_v);
      if (exp_v) begin
        chk("m_cdb_rob", cdbRob, exp_e.rob);
        chk("m_cdb_result", cdbResult, exp_e.res);
        chk("m_cdb_control", cdbControl, exp_e.ctrl);
        if (exp_e.is_br) chk("m_cdb_address", cdbAddress, exp_e.addr);
      end
`ifdef FU_PERF_CNT_EN
      chk("m_stall_cycles", stallCycles, stall_m);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    aluValid = '0;
    brValid  = 1'b0;
  endtask

  task automatic drive_alu(input int ch, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [3:0] op, input logic [R-1:0] rob);
    aluValid[ch]         = 1'b1;
    aluSrc1[ch*W +: W]   = a;
    aluSrc2[ch*W +: W]   = b;
    aluControl[ch*4 +: 4] = op;
    aluRob[ch*R +: R]    = rob;
  endtask

  task automatic drive_br(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] tgt, input logic [W-1:0] ppc,
                          input logic [W-1:0] p4, input logic [W-1:0] link,
                          input logic pt, input logic [1:0] cs, input logic [R-1:0] rob);
    brValid        = 1'b1;
    branchControl  = op;
    bSrc1          = a;
    bSrc2          = b;
    targetAddress  = tgt;
    predictedPC    = ppc;
    pcPlus4        = p4;
    linkValue      = link;
    predictedTaken = pt;
    counterState   = cs;
    branchRob      = rob;
  endtask

  task automatic pulse_reset();
    globalReset = 1'b1;
    @(negedge clk);
    globalReset = 1'b0;
  endtask

  initial begin
    aluSrc1 = '0; aluSrc2 = '0; aluControl = '0; aluRob = '0;
    drive_br(3'd0, '0, '0, '0, '0, '0, '0, 1'b0, 2'd0, '0);
    idle();
`ifdef FU_PERF_CNT_EN
    perfClear = 1'b0;
`endif
    globalReset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_cdb_valid", cdbValid, 1'b0);
    chk("reset_cdb_rob", cdbRob, 3'd0);
    chk("reset_cdb_result", cdbResult, 32'd0);
    chk("reset_alu_avail", aluAvailable, 2'b11);
    chk("reset_br_avail", branchAvailable, 1'b1);
    globalReset = 1'b0;

    // ADD 5+7 on ALU0: visible two cycles after issue
    drive_alu(0, 32'd5, 32'd7, 4'd0, 3'd3);
    @(negedge clk); idle();
    chk("add_t1_valid", cdbValid, 1'b0);
    @(negedge clk);
    chk("add_t2_valid", cdbValid, 1'b1);
    chk("add_t2_rob", cdbRob, 3'd3);
    chk("add_t2_result", cdbResult, 32'd12);
    chk("add_t2_control", cdbControl, 7'd0);

    // Three-way contention after reset: branch, ALU0, ALU1
    pulse_reset();
    drive_alu(0, 32'd1, 32'd1, 4'd0, 3'd1);
    drive_alu(1, 32'd9, 32'd4, 4'd1, 3'd2);
    drive_br(3'd0, 32'd4, 32'd4, 32'h100, 32'h100, 32'h204, 32'h208, 1'b0, 2'd1, 3'd5);
    @(negedge clk); idle();
    @(negedge clk);
    chk("beq_rob", cdbRob, 3'd5);
    chk("beq_control", cdbControl, 7'h57);
    chk("beq_address", cdbAddress, 32'h100);
    chk("beq_result", cdbResult, 32'h208);
    @(negedge clk);
    chk("cont_alu0_rob", cdbRob, 3'd1);
    chk("cont_alu0_result", cdbResult, 32'd2);
    @(negedge clk);
    chk("cont_alu1_rob", cdbRob, 3'd2);
    chk("cont_alu1_result", cdbResult, 32'd5);
    drive_alu(0, 32'd3, 32'd3, 4'd2, 3'd6);
    drive_alu(1, 32'd3, 32'd3, 4'd3, 3'd7);
    @(negedge clk); idle();
    chk("cont_gap_valid", cdbValid, 1'b0);
    @(negedge clk);
    chk("wrap_first_rob", cdbRob, 3'd6);
    @(negedge clk);
    chk("wrap_second_rob", cdbRob, 3'd7);

    // BNE not taken, correctly predicted
    drive_br(3'd1, 32'd4, 32'd4, 32'h500, 32'h500, 32'h300, 32'h304, 1'b0, 2'd0, 3'd4);
    @(negedge clk); idle();
    @(negedge clk);
    chk("bne_valid", cdbValid, 1'b1);
    chk("bne_control", cdbControl, 7'h01);
    chk("bne_address", cdbAddress, 32'h300);

    // Held ALU0 issue against continuous branch issue
    pulse_reset();
    drive_alu(0, 32'd8, 32'd1, 4'd0, 3'd1);
    drive_br(3'd6, '0, '0, 32'h40, 32'h40, 32'h44, 32'h44, 1'b1, 2'd3, 3'd2);
    @(negedge clk); chk("hold_c1_avail", aluAvailable[0], 1'b1);
    @(negedge clk); chk("hold_c2_avail", aluAvailable[0], 1'b0);
    @(negedge clk); chk("hold_c3_avail", aluAvailable[0], 1'b1);
    @(negedge clk); chk("hold_c4_avail", aluAvailable[0], 1'b0);

    // Reset while ALU0 is full and issue still asserted
    globalReset = 1'b1;
    @(negedge clk);
    globalReset = 1'b0;
    idle();
    chk("rst_full_alu_avail", aluAvailable, 2'b11);
    chk("rst_full_br_avail", branchAvailable, 1'b1);
    chk("rst_full_valid", cdbValid, 1'b0);
    @(negedge clk); chk("rst_full_stale1", cdbValid, 1'b0);
    @(negedge clk); chk("rst_full_stale2", cdbValid, 1'b0);

`ifdef FU_PERF_CNT_EN
    drive_br(3'd6, '0, '0, '0, '0, '0, '0, 1'b1, 2'd3, 3'd0);
    repeat (4) @(negedge clk);
    idle();
    perfClear = 1'b1;
    @(negedge clk);
    perfClear = 1'b0;
    chk("perf_clear", stallCycles, 32'd0);
`endif

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      aluValid = 2'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) begin
        aluSrc1[i*W +: W]    = $urandom;
        aluSrc2[i*W +: W]    = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : $urandom;
        aluControl[i*4 +: 4] = 4'($urandom_range(0, 11));
        aluRob[i*R +: R]     = 3'($urandom);
      end
      brValid        = ($urandom_range(0, 2) == 0);
      branchControl  = 3'($urandom);
      bSrc1          = $urandom;
      bSrc2          = ($urandom_range(0, 1) == 0) ? bSrc1 : $urandom;
      targetAddress  = $urandom;
      predictedPC    = ($urandom_range(0, 1) == 0) ? targetAddress : $urandom;
      pcPlus4        = $urandom;
      linkValue      = $urandom;
      predictedTaken = 1'($urandom);
      counterState   = 2'($urandom);
      branchRob      = 3'($urandom);
      globalReset    = ($urandom_range(0, 80) == 0);
`ifdef FU_PERF_CNT_EN
      perfClear      = ($urandom_range(0, 50) == 0);
`endif
      @(negedge clk);
    end
    idle();
    globalReset = 1'b0;
    repeat (6) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
